// File: rtl/operand_issue.sv
// Issue stage: register file with write-through, load scoreboard, hazard stall,
// and the ID/EX pipeline register feeding execute.
module operand_issue #(
  parameter int XLEN        = 32,
  parameter int PCLEN       = 10,
  parameter int STALL_LIMIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  input  logic             writesRd,
  input  logic [XLEN-1:0]  imm,
  input  logic [11:0]      code,
  input  logic             isLoad,
  input  logic             isBranch,
  input  logic [PCLEN-1:0] pcIn,
  input  logic             flush,
  input  logic             wbEnable,
  input  logic [4:0]       wbRd,
  input  logic [XLEN-1:0]  wbData,
  input  logic             wbIsLoad,
  output logic             stall,
  output logic             exValid,
  output logic [XLEN-1:0]  exRs1Val,
  output logic [XLEN-1:0]  exRs2Val,
  output logic [XLEN-1:0]  exImm,
  output logic [11:0]      exCode,
  output logic [4:0]       exRd,
  output logic             exIsLoad,
  output logic             exIsBranch,
  output logic [PCLEN-1:0] exPc,
  output logic [4:0]       lastRd,
  output logic             hazardTimeout
);

  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STALL_LIMIT);

  logic [XLEN-1:0] regs_r [32];
  logic [31:0]     pending_r;
  logic [CW-1:0]   stall_cnt_r;
  logic [31:0]     clr_s;
  logic [31:0]     set_s;
  logic [31:0]     live_s;
  logic            hazard_s;
  logic            issue_s;
  logic [CW-1:0]   cnt_next_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  logic [4:0]      dest_s;

  // Scoreboard release/set vectors and the hazard decision
  always_comb begin
    clr_s = 32'd0;
    set_s = 32'd0;
    if (wbEnable && wbIsLoad) begin
      clr_s[wbRd] = 1'b1;
    end else begin
      clr_s = 32'd0;
    end
    clr_s[0] = 1'b0;
    live_s   = pending_r & ~clr_s;
    if (inValid) begin
      hazard_s = live_s[rs1] | live_s[rs2] | (writesRd & live_s[rd]);
    end else begin
      hazard_s = 1'b0;
    end
    stall   = hazard_s && !flush;
    issue_s = inValid && !hazard_s && !flush;
    dest_s  = writesRd ? rd : 5'd0;
    if (issue_s && isLoad && (dest_s != 5'd0)) begin
      set_s[dest_s] = 1'b1;
    end else begin
      set_s = 32'd0;
    end
    set_s[0] = 1'b0;
  end

  // Operand read: x0 is hardwired zero, a same-cycle writeback bypasses the array
  always_comb begin
    if (rs1 == 5'd0) begin
      rs1_val_s = {XLEN{1'b0}};
    end else if (wbEnable && (wbRd == rs1)) begin
      rs1_val_s = wbData;
    end else begin
      rs1_val_s = regs_r[rs1];
    end
    if (rs2 == 5'd0) begin
      rs2_val_s = {XLEN{1'b0}};
    end else if (wbEnable && (wbRd == rs2)) begin
      rs2_val_s = wbData;
    end else begin
      rs2_val_s = regs_r[rs2];
    end
  end

  // Saturating count of consecutive stall cycles
  always_comb begin
    if (!stall) begin
      cnt_next_s = {CW{1'b0}};
    end else if (stall_cnt_r == LIMIT_C) begin
      cnt_next_s = stall_cnt_r;
    end else begin
      cnt_next_s = stall_cnt_r + CW'(1);
    end
  end

  // Register file, scoreboard and stall counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
      pending_r     <= 32'd0;
      stall_cnt_r   <= {CW{1'b0}};
      hazardTimeout <= 1'b0;
    end else begin
      if (wbEnable && (wbRd != 5'd0)) begin
        regs_r[wbRd] <= wbData;
      end
      // set is OR-ed after the clear so a same-index set wins
      pending_r     <= live_s | set_s;
      stall_cnt_r   <= cnt_next_s;
      hazardTimeout <= hazardTimeout | (cnt_next_s == LIMIT_C);
    end
  end

  // ID/EX pipeline register; fields hold on bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      exValid    <= 1'b0;
      exRs1Val   <= {XLEN{1'b0}};
      exRs2Val   <= {XLEN{1'b0}};
      exImm      <= {XLEN{1'b0}};
      exCode     <= 12'd0;
      exRd       <= 5'd0;
      exIsLoad   <= 1'b0;
      exIsBranch <= 1'b0;
      exPc       <= {PCLEN{1'b0}};
      lastRd     <= 5'd0;
    end else if (issue_s) begin
      exValid    <= 1'b1;
      exRs1Val   <= rs1_val_s;
      exRs2Val   <= rs2_val_s;
      exImm      <= imm;
      exCode     <= code;
      exRd       <= dest_s;
      exIsLoad   <= isLoad;
      exIsBranch <= isBranch;
      exPc       <= pcIn;
      lastRd     <= dest_s;
    end else begin
      exValid    <= 1'b0;
      lastRd     <= 5'd0;
    end
  end

endmodule
